// File: rtl/writeback_stage_pkg.sv
// Shared write-back encodings: register-file source select and load funct3 codes.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'b00,
        WB_SRC_MEM = 2'b01,
        WB_SRC_PC4 = 2'b10,
        WB_SRC_IMM = 2'b11
    } wb_src_e;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load formatter: extracts byte/half/word at the byte offset, extends it,
// and flags misaligned or illegal loads (raw data is passed through on a flag).
module load_align
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] data_i,
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        offset_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              misalign_o
);

    localparam bit IS64 = (DWIDTH == 64);

    logic [2:0]        off;
    logic [DWIDTH-1:0] shifted;
    logic              unused_off_hi;

    // Offset bit 2 only selects a word lane on a doubleword bus.
    assign off           = IS64 ? offset_i : {1'b0, offset_i[1:0]};
    assign unused_off_hi = offset_i[2];
    assign shifted       = data_i >> {off, 3'b000};

    always_comb begin
        data_o     = data_i;
        misalign_o = 1'b0;
        case (funct3_i)
            LD_B:  data_o = DWIDTH'($signed(shifted[7:0]));
            LD_BU: data_o = DWIDTH'(shifted[7:0]);
            LD_H: begin
                misalign_o = off[0];
                data_o     = DWIDTH'($signed(shifted[15:0]));
            end
            LD_HU: begin
                misalign_o = off[0];
                data_o     = DWIDTH'(shifted[15:0]);
            end
            LD_W: begin
                misalign_o = (off[1:0] != 2'b00);
                data_o     = DWIDTH'($signed(shifted[31:0]));
            end
            LD_WU: begin
                misalign_o = !IS64 || (off[1:0] != 2'b00);
                data_o     = DWIDTH'(shifted[31:0]);
            end
            LD_D: begin
                misalign_o = !IS64 || (off != 3'b000);
                data_o     = data_i;
            end
            default: misalign_o = 1'b1;
        endcase
        if (misalign_o) data_o = data_i;
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered write-back stage: pipeline register, source mux, x0 gating, load formatting.
// Optional retired-instruction counter enabled by `define WRITEBACK_RETIRE_CNT_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [4:0]        rd_i,
    input  logic              regwen_i,
    input  logic [1:0]        wb_src_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] memory_data_i,
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        addr_lo_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [4:0]        rd_o,
    output logic              regwen_o,
    output logic [DWIDTH-1:0] writeback_data_o,
    output logic              misalign_o,
    output logic [63:0]       retire_cnt_o
);

    logic              valid_q, valid_d;
    logic              regwen_q, regwen_d;
    logic              misalign_q, misalign_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [4:0]        rd_q, rd_d;
    logic [DWIDTH-1:0] data_q, data_d;

    logic              cap, live, is_mem, ld_mis, mis;
    logic [DWIDTH-1:0] ld_data, src_data;
    logic [AWIDTH-1:0] pc_plus4;

    load_align #(.DWIDTH(DWIDTH)) u_load_align (
        .data_i     (memory_data_i),
        .funct3_i   (funct3_i),
        .offset_i   (addr_lo_i),
        .data_o     (ld_data),
        .misalign_o (ld_mis)
    );

    assign cap      = ~stall_i;
    assign live     = valid_i & ~flush_i;
    assign is_mem   = (wb_src_i == WB_SRC_MEM);
    assign mis      = is_mem & ld_mis;
    assign pc_plus4 = pc_i + AWIDTH'(4);

    always_comb begin
        src_data = alu_res_i;
        case (wb_src_e'(wb_src_i))
            WB_SRC_ALU: src_data = alu_res_i;
            WB_SRC_MEM: src_data = ld_data;
            WB_SRC_PC4: src_data = DWIDTH'(pc_plus4);
            WB_SRC_IMM: src_data = imm_i;
            default:    src_data = alu_res_i;
        endcase
    end

    // Flush kills the control bits even while stalled; payload bits are don't-care then.
    always_comb begin
        valid_d    = valid_q;
        regwen_d   = regwen_q;
        misalign_d = misalign_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        data_d     = data_q;
        if (flush_i) begin
            valid_d    = 1'b0;
            regwen_d   = 1'b0;
            misalign_d = 1'b0;
        end
        if (cap) begin
            valid_d    = live;
            regwen_d   = live & regwen_i & (rd_i != 5'd0) & ~mis;
            misalign_d = ~flush_i & mis;
            pc_d       = pc_i;
            rd_d       = rd_i;
            data_d     = src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwen_q   <= 1'b0;
            misalign_q <= 1'b0;
            pc_q       <= '0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            regwen_q   <= regwen_d;
            misalign_q <= misalign_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    assign valid_o          = valid_q;
    assign regwen_o         = regwen_q;
    assign misalign_o       = misalign_q;
    assign pc_o             = pc_q;
    assign rd_o             = rd_q;
    assign writeback_data_o = data_q;

`ifdef WRITEBACK_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    assign cnt_d = (cap & live) ? cnt_q + 64'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign retire_cnt_o = cnt_q;
`else
    assign retire_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a spec-level reference model checked every cycle.
module tb_writeback_stage;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset, valid_i, stall_i, flush_i, regwen_i;
    logic [AW-1:0] pc_i;
    logic [4:0]    rd_i;
    logic [1:0]    wb_src_i;
    logic [DW-1:0] alu_res_i, imm_i, memory_data_i;
    logic [2:0]    funct3_i, addr_lo_i;
    logic          valid_o, regwen_o, misalign_o;
    logic [AW-1:0] pc_o;
    logic [4:0]    rd_o;
    logic [DW-1:0] writeback_data_o;
    logic [63:0]   retire_cnt_o;

    int checks = 0;
    int failures = 0;

    writeback_stage #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .pc_i(pc_i), .rd_i(rd_i), .regwen_i(regwen_i), .wb_src_i(wb_src_i),
        .alu_res_i(alu_res_i), .imm_i(imm_i), .memory_data_i(memory_data_i),
        .funct3_i(funct3_i), .addr_lo_i(addr_lo_i), .valid_o(valid_o), .pc_o(pc_o),
        .rd_o(rd_o), .regwen_o(regwen_o), .writeback_data_o(writeback_data_o),
        .misalign_o(misalign_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load formatting from first principles: size/sign table, offset divisibility, masking.
    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] m, input logic [2:0] f,
                                          input logic [2:0] o, output logic mis);
        longint unsigned v, mask;
        int sz, oo;
        bit sgn;
        sz = 0; sgn = 0; mis = 0;
        oo = int'(o) % (DW / 8);
        case (f)
            3'd0: begin sz = 1; sgn = 1; end
            3'd4: begin sz = 1; sgn = 0; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd5: begin sz = 2; sgn = 0; end
            3'd2: begin sz = 4; sgn = 1; end
            default: mis = 1;
        endcase
        if (!mis && (oo % sz) != 0) mis = 1;
        if (mis) return m;
        mask = (64'd1 << (8 * sz)) - 1;
        v = (longint'(m) >> (8 * oo)) & mask;
        if (sgn && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        return v[DW-1:0];
    endfunction

    logic          e_v, e_rw, e_mis, e_dk;
    logic [AW-1:0] e_pc;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_d;
    longint        e_cnt;

    always @(posedge clk) begin
        logic          ml, ok;
        logic [DW-1:0] dat;
        logic [AW-1:0] p4;
        if (reset) begin
            e_v = 0; e_rw = 0; e_mis = 0; e_pc = 0; e_rd = 0; e_d = 0; e_dk = 1; e_cnt = 0;
        end else if (!stall_i) begin
            ml = 0;
            p4 = pc_i + 4;
            case (wb_src_i)
                2'd0: dat = alu_res_i;
                2'd1: dat = fmt(memory_data_i, funct3_i, addr_lo_i, ml);
                2'd2: dat = DW'(p4);
                default: dat = imm_i;
            endcase
            ok    = valid_i && !flush_i;
            e_v   = ok;
            e_pc  = pc_i;
            e_rd  = rd_i;
            e_d   = dat;
            e_mis = !flush_i && ml;
            e_rw  = ok && regwen_i && rd_i != 0 && !ml;
            e_dk  = !flush_i;
            if (ok) e_cnt++;
        end else if (flush_i) begin
            e_v = 0; e_rw = 0; e_mis = 0; e_dk = 0;
        end
    end

    always @(negedge clk) begin
        chk("valid_o", 64'(valid_o), 64'(e_v));
        chk("regwen_o", 64'(regwen_o), 64'(e_rw));
        chk("misalign_o", 64'(misalign_o), 64'(e_mis));
`ifdef WRITEBACK_RETIRE_CNT_EN
        chk("retire_cnt_o", retire_cnt_o, e_cnt);
`else
        chk("retire_cnt_o", retire_cnt_o, 64'd0);
`endif
        if (e_dk) begin
            chk("pc_o", 64'(pc_o), 64'(e_pc));
            chk("rd_o", 64'(rd_o), 64'(e_rd));
            chk("writeback_data_o", 64'(writeback_data_o), 64'(e_d));
        end
    end

    task automatic ld(input logic [2:0] f, input logic [2:0] o);
        wb_src_i = 2'd1; funct3_i = f; addr_lo_i = o;
        @(negedge clk);
    endtask

    initial begin
        reset = 1; valid_i = 1; stall_i = 0; flush_i = 0; regwen_i = 1;
        pc_i = 32'h100; rd_i = 5'd3; wb_src_i = 2'd0; alu_res_i = 32'hDEAD;
        imm_i = 32'h5000; memory_data_i = 32'h80FF7F01; funct3_i = 3'd0; addr_lo_i = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst valid", 64'(valid_o), 0);
        chk("rst regwen", 64'(regwen_o), 0);
        chk("rst data", 64'(writeback_data_o), 0);
        chk("rst pc_rd", 64'({pc_o, rd_o}), 0);

        reset = 0; alu_res_i = 32'h1234; rd_i = 5'd5; wb_src_i = 2'd0;
        @(negedge clk);
        chk("first alu data", 64'(writeback_data_o), 64'h1234);
        chk("first regwen", 64'(regwen_o), 1);

        ld(3'b000, 3'd3); chk("LB o3", 64'(writeback_data_o), 64'hFFFFFF80);
        ld(3'b100, 3'd3); chk("LBU o3", 64'(writeback_data_o), 64'h00000080);
        ld(3'b001, 3'd2); chk("LH o2", 64'(writeback_data_o), 64'hFFFF80FF);
        ld(3'b101, 3'd0); chk("LHU o0", 64'(writeback_data_o), 64'h00007F01);
        ld(3'b001, 3'd1);
        chk("LH o1 mis", 64'(misalign_o), 1);
        chk("LH o1 regwen", 64'(regwen_o), 0);
        chk("LH o1 data", 64'(writeback_data_o), 64'h80FF7F01);
        ld(3'b010, 3'd2);
        chk("LW o2 mis", 64'(misalign_o), 1);
        chk("LW o2 data", 64'(writeback_data_o), 64'h80FF7F01);
        ld(3'b011, 3'd0); chk("LD on 32b mis", 64'(misalign_o), 1);
        ld(3'b010, 3'd0);
        ld(3'b110, 3'd0);
        ld(3'b111, 3'd0);
        ld(3'b000, 3'd1);
        ld(3'b101, 3'd2);

        wb_src_i = 2'd0; funct3_i = 3'b001; addr_lo_i = 3'd1;
        @(negedge clk); chk("non-MEM no mis", 64'(misalign_o), 0);

        wb_src_i = 2'd2; pc_i = 32'hFFFFFFFC;
        @(negedge clk); chk("PC4 wrap", 64'(writeback_data_o), 0);
        pc_i = 32'h0000_0100;
        @(negedge clk); chk("PC4", 64'(writeback_data_o), 64'h104);
        wb_src_i = 2'd3; imm_i = 32'hABCD_E000;
        @(negedge clk); chk("IMM", 64'(writeback_data_o), 64'hABCDE000);

        wb_src_i = 2'd0; rd_i = 5'd0; regwen_i = 1;
        @(negedge clk);
        chk("x0 regwen", 64'(regwen_o), 0);
        chk("x0 valid", 64'(valid_o), 1);
        valid_i = 0; rd_i = 5'd4;
        @(negedge clk); chk("invalid regwen", 64'(regwen_o), 0);

        valid_i = 1; alu_res_i = 32'hAAAA; rd_i = 5'd7;
        @(negedge clk);
        stall_i = 1; alu_res_i = 32'hBBBB; rd_i = 5'd9;
        repeat (2) begin
            @(negedge clk);
            chk("stall data", 64'(writeback_data_o), 64'hAAAA);
            chk("stall rd", 64'(rd_o), 7);
        end
        flush_i = 1;
        @(negedge clk);
        chk("stall+flush valid", 64'(valid_o), 0);
        chk("stall+flush regwen", 64'(regwen_o), 0);
        flush_i = 0;

        // Reset while stalled drops the held payload; then the retire-count scenario.
        alu_res_i = 32'h7777; rd_i = 5'd6;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst in stall valid", 64'(valid_o), 0);
        chk("rst in stall data", 64'(writeback_data_o), 0);
        reset = 0; stall_i = 0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1; flush_i = (i == 3 || i == 7);
            alu_res_i = 32'h100 + 32'(i); rd_i = 5'(i + 1);
            @(negedge clk);
        end
        flush_i = 0; stall_i = 1;
        repeat (3) @(negedge clk);
        stall_i = 0; valid_i = 0;
        @(negedge clk);
`ifdef WRITEBACK_RETIRE_CNT_EN
        chk("retire count", retire_cnt_o, 64'd8);
`else
        chk("retire count off", retire_cnt_o, 64'd0);
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered write-back stage: captures the MEM/WB pipeline payload, formats load data (byte/half/word, signed/unsigned, byte-lane aligned), selects the register-file write value from four sources, and drives the register-file write port plus forwarding copies. It replaces the bare combinational write-back mux between the memory stage and the register file, adding stall/flush handling, `rd`=x0 suppression and misalignment flagging.

## Interface
- `DWIDTH`, 32: data width; legal values 32 or 64.
- `AWIDTH`, 32: PC/address width.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: MEM-stage payload valid.
- `stall_i` in 1: hold WB register contents.
- `flush_i` in 1: kill payload being captured.
- `pc_i` in AWIDTH: instruction PC.
- `rd_i` in 5: destination register.
- `regwen_i` in 1: instruction writes `rd`.
- `wb_src_i` in 2: ALU=00, MEM=01, PC4=10, IMM=11.
- `alu_res_i` in DWIDTH: ALU result.
- `imm_i` in DWIDTH: immediate (LUI).
- `memory_data_i` in DWIDTH: raw aligned memory word/doubleword.
- `funct3_i` in 3: load size/sign code.
- `addr_lo_i` in 3: low byte-address bits of the load (bit 2 used only when DWIDTH=64).
- `valid_o` out 1: WB payload valid.
- `pc_o` out AWIDTH: registered PC.
- `rd_o` out 5: registered destination.
- `regwen_o` out 1: register-file write enable.
- `writeback_data_o` out DWIDTH: register-file write data; also the forwarding value.
- `misalign_o` out 1: registered load-misalignment flag.
- `retire_cnt_o` out 64: retired-instruction count (see Configuration).

## Operation
- Capture condition `cap = ~stall_i`. On `cap`: `valid_o <= valid_i & ~flush_i`; `pc_o`, `rd_o` and the formatted data are loaded; `regwen_o <= valid_i & ~flush_i & regwen_i & (rd_i != 0)`.
- `stall_i=1` and `flush_i=0`: all outputs hold.
- `flush_i=1`: `valid_o`, `regwen_o` and `misalign_o` clear next edge regardless of `stall_i`; the data/pc/rd registers may take any value.
- Source select: ALU → `alu_res_i`; MEM → formatted load; PC4 → zero-extend(`pc_i` + 4) truncated to AWIDTH before extension (wraps at 2^AWIDTH); IMM → `imm_i`.
- Load format, with byte offset `o = addr_lo_i`:
  - LB 000 and LBU 100 take byte `o`.
  - LH 001 and LHU 101 take the half at `o`.
  - LW 010 and LWU 110 take the word at `o`.
  - LD 011 takes the whole doubleword.
  - Signed codes sign-extend to DWIDTH; unsigned codes zero-extend.
  - LD, LWU and offset bit 2 exist only when DWIDTH=64; with DWIDTH=32 they are illegal.
- Misalignment: a half with `o[0]=1`, a word with `o[1:0]!=0`, a double with `o!=0`, or an illegal funct3.
  - Result: `misalign_o=1`, data = raw `memory_data_i`, `regwen_o` forced 0.
  - Evaluated only when `wb_src_i`=MEM; otherwise `misalign_o=0`.

## Timing
- Latency is exactly 1 cycle from input to outputs; no combinational path from inputs to outputs.
- Reset: `valid_o`, `regwen_o`, `misalign_o`, `pc_o`, `rd_o`, `writeback_data_o` = 0; `retire_cnt_o` = 0.
- Reset dominates flush and stall. Reset asserted mid-stall discards the held payload.
- Priority: reset > flush > stall > capture.

## Configuration
- `WRITEBACK_RETIRE_CNT_EN` defined: 64-bit counter increments on every edge where `cap & valid_i & ~flush_i & ~reset`; it wraps at 2^64 to 0. `retire_cnt_o` = counter.
- Not defined: no counter flops; `retire_cnt_o` tied to 0.

## Structure
- Shared package (`constants.svh`): keep the existing `WB_SRC_ALU/MEM/PC4`, add `WB_SRC_IMM`=2'b11; add load funct3 constants `LD_B, LD_H, LD_W, LD_D, LD_BU, LD_HU, LD_WU`.
- Sub-module `load_align` (combinational; DWIDTH parameter; inputs raw data, funct3, offset; outputs formatted data and misalign flag).
- Top module holds the pipeline register, source mux, x0 gating and the optional counter.

## Test plan
- Reset 3 cycles with `valid_i=1` → all outputs 0. First capture after reset releases: `alu_res_i`=0x1234, `rd_i`=5, ALU → next cycle data 0x1234, `regwen_o=1`.
- `memory_data_i`=0x80FF7F01, MEM: LB o=3 → 0xFFFFFF80; LBU o=3 → 0x00000080; LH o=2 → 0xFFFF80FF; LHU o=0 → 0x00007F01.
- LH o=1 and LW o=2 → `misalign_o=1`, `regwen_o=0`, data=0x80FF7F01. DWIDTH=32 with funct3=011 → misaligned.
- `pc_i`=0xFFFFFFFC, PC4 → data 0x00000000. `rd_i`=0 with `regwen_i=1` → `regwen_o=0`, `valid_o=1`.
- Capture A, then `stall_i=1` for 2 cycles with new inputs → outputs stay A. `stall_i=1` with `flush_i=1` → `valid_o=0`, `regwen_o=0`.
- Macro on: 10 valid captures, 2 flushed, 3 stalled cycles → `retire_cnt_o`=8. Macro off → 0 throughout.
